// File: rtl/game_tick_gen.sv
// game_tick_gen: level-scaled game tick strobe with run/pause, single-step and a running tick count.
// The period is latched only at a wrap, so level changes never disturb the interval in progress.
module game_tick_gen #(
  parameter int BASE_PERIOD  = 20_000_000,
  parameter int STEP         = 2_000_000,
  parameter int MIN_PERIOD   = 5_000_000,
  parameter int LEVEL_W      = 4,
  parameter int CNT_W        = 26,
  parameter bit START_PAUSED = 1'b1
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               pause_toggle,
  input  logic               step,
  input  logic               level_up,
  input  logic               level_clr,
  output logic               game_tick,
  output logic               paused,
  output logic [LEVEL_W-1:0] level,
  output logic [15:0]        tick_count
);
  localparam int PW = CNT_W + 1;
  localparam logic [63:0] BASE = 64'(BASE_PERIOD);
  localparam logic [63:0] FLOOR = 64'(MIN_PERIOD);
  localparam logic [PW-1:0] RST_PERIOD = PW'(BASE > FLOOR ? BASE : FLOOR);
  typedef enum logic {RUN, PAUSED} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0] period_q, period_d, next_period;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [15:0] tc_q, tc_d;
  logic tick_q, tick_d;
  logic [63:0] red;
  logic wrap;
  // clamp by comparing the reduction against the headroom, so the subtraction never wraps
  assign red = 64'(level_q) * 64'(STEP);
  assign next_period = (BASE <= FLOOR || red >= BASE - FLOOR) ? PW'(FLOOR) : PW'(BASE - red);
  assign wrap = state_q == RUN && {1'b0, cnt_q} == period_q - PW'(1);
  always_comb begin
    state_d = pause_toggle ? (state_q == RUN ? PAUSED : RUN) : state_q;
    cnt_d = state_q != RUN ? cnt_q : wrap ? '0 : cnt_q + CNT_W'(1);
    period_d = wrap ? next_period : period_q;
    tick_d = wrap || (state_q == PAUSED && step);
    tc_d = tc_q + 16'(tick_d);
    level_d = level_clr ? '0 : (level_up && level_q != '1) ? level_q + LEVEL_W'(1) : level_q;
  end
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) begin
      state_q <= START_PAUSED ? PAUSED : RUN;
      cnt_q <= '0;
      period_q <= RST_PERIOD;
      level_q <= '0;
      tc_q <= '0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      period_q <= period_d;
      level_q <= level_d;
      tc_q <= tc_d;
      tick_q <= tick_d;
    end
  assign game_tick = tick_q;
  assign paused = state_q == PAUSED;
  assign level = level_q;
  assign tick_count = tc_q;
endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: scoreboard bench; tasks queue expected ticks, a monitor pops and checks them.
module tb_game_tick_gen;
  logic clk_100MHz = 1'b0;
  logic reset, pause_toggle, step, level_up, level_clr;
  logic game_tick, paused;
  logic [2:0] level;
  logic [15:0] tick_count;
  typedef struct { int cyc; int cnt; } ev_t;
  ev_t exp_q[$];
  ev_t front;
  int cyc = 0;
  int exp_tc = 0;
  int vectors = 0;
  int errors = 0;
  int base;

  game_tick_gen #(.BASE_PERIOD(10), .STEP(2), .MIN_PERIOD(4), .LEVEL_W(3), .CNT_W(4), .START_PAUSED(1'b1)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .pause_toggle(pause_toggle), .step(step),
    .level_up(level_up), .level_clr(level_clr), .game_tick(game_tick), .paused(paused),
    .level(level), .tick_count(tick_count)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Scoreboard consumer: a tick observed after edge N must match the queue head for edge N.
  always @(posedge clk_100MHz) begin
    cyc++;
    #1;
    if (game_tick) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: tick at edge %0d tick_count=%0d, required no tick", cyc, tick_count);
      end else begin
        front = exp_q.pop_front();
        if (cyc !== front.cyc || tick_count !== 16'(front.cnt)) begin
          errors++;
          $display("FAIL tick_match: edge %0d count %0d, required edge %0d count %0d", cyc, tick_count, front.cyc, front.cnt);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      vectors++;
      errors++;
      front = exp_q.pop_front();
      $display("FAIL missed_tick: no tick by edge %0d, required at edge %0d", cyc, front.cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic expect_tick(input int c);
    ev_t ev;
    exp_tc++;
    ev.cyc = c;
    ev.cnt = exp_tc;
    exp_q.push_back(ev);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e - 1) @(negedge clk_100MHz);
  endtask

  task automatic drive(input int e, input logic pt, input logic st, input logic lu, input logic lc);
    wait_edge(e);
    pause_toggle = pt; step = st; level_up = lu; level_clr = lc;
    @(negedge clk_100MHz);
    pause_toggle = 1'b0; step = 1'b0; level_up = 1'b0; level_clr = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_100MHz);
    vectors += 4;
    if (game_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b, required 0", game_tick); end
    if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d, required 0", level); end
    if (tick_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", tick_count); end
    if (paused !== 1'b1) begin errors++; $display("FAIL reset_paused: got %b, required 1", paused); end
    reset = 1'b0;
  endtask

  task automatic test_run_rate;
    int e0;
    e0 = cyc + 2;
    expect_tick(e0 + 10);
    expect_tick(e0 + 20);
    expect_tick(e0 + 30);
    drive(e0, 1, 0, 0, 0);
    vectors++;
    if (paused !== 1'b0) begin errors++; $display("FAIL run_paused: got %b, required 0", paused); end
    wait_edge(e0 + 31);
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL run_pending: %0d ticks outstanding, required 0", exp_q.size()); end
    base = e0 + 30;
  endtask

  task automatic test_level;
    int w;
    w = base;
    expect_tick(w + 10);
    expect_tick(w + 14);
    expect_tick(w + 18);
    expect_tick(w + 22);
    expect_tick(w + 32);
    for (int i = 3; i <= 5; i++) drive(w + i, 0, 0, 1, 0);
    vectors++;
    if (level !== 3'd3) begin errors++; $display("FAIL level_3: got %0d, required 3", level); end
    for (int i = 11; i <= 12; i++) drive(w + i, 0, 0, 1, 0);
    vectors++;
    if (level !== 3'd5) begin errors++; $display("FAIL level_5: got %0d, required 5", level); end
    for (int i = 15; i <= 19; i++) drive(w + i, 0, 0, 1, 0);
    vectors++;
    if (level !== 3'd7) begin errors++; $display("FAIL level_sat: got %0d, required 7", level); end
    drive(w + 20, 0, 0, 0, 1);
    vectors++;
    if (level !== 3'd0) begin errors++; $display("FAIL level_clr: got %0d, required 0", level); end
    wait_edge(w + 33);
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL level_pending: %0d ticks outstanding, required 0", exp_q.size()); end
    base = w + 32;
  endtask

  task automatic test_pause;
    int w, r;
    w = base;
    r = w + 54;
    drive(w + 4, 1, 0, 0, 0);
    wait_edge(w + 30);
    vectors++;
    if (paused !== 1'b1) begin errors++; $display("FAIL pause_hold: got %b, required 1", paused); end
    expect_tick(r + 6);
    drive(r, 1, 0, 0, 0);
    vectors++;
    if (paused !== 1'b0) begin errors++; $display("FAIL pause_resume: got %b, required 0", paused); end
    wait_edge(r + 7);
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL pause_pending: %0d ticks outstanding, required 0", exp_q.size()); end
    base = r + 6;
  endtask

  task automatic test_step;
    int p;
    p = base;
    drive(p + 3, 1, 0, 0, 0);
    expect_tick(p + 10);
    drive(p + 10, 0, 1, 0, 0);
    vectors++;
    if (tick_count !== 16'(exp_tc)) begin errors++; $display("FAIL step_count: got %0d, required %0d", tick_count, exp_tc); end
    expect_tick(p + 22);
    drive(p + 15, 1, 0, 0, 0);
    expect_tick(p + 32);
    drive(p + 25, 0, 1, 0, 0);
    wait_edge(p + 33);
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL step_pending: %0d ticks outstanding, required 0", exp_q.size()); end
    base = p + 32;
  endtask

  task automatic test_simultaneous;
    int q;
    q = base;
    expect_tick(q + 10);
    drive(q + 10, 1, 0, 0, 0);
    vectors++;
    if (paused !== 1'b1) begin errors++; $display("FAIL wrap_pause: got %b, required 1", paused); end
    for (int i = 11; i <= 16; i++) drive(q + i, 0, 0, 1, 0);
    vectors++;
    if (level !== 3'd6) begin errors++; $display("FAIL level_6: got %0d, required 6", level); end
    drive(q + 17, 0, 0, 1, 1);
    vectors++;
    if (level !== 3'd0) begin errors++; $display("FAIL clr_wins: got %0d, required 0", level); end
    expect_tick(q + 18);
    expect_tick(q + 28);
    drive(q + 18, 1, 1, 0, 0);
    vectors++;
    if (paused !== 1'b0) begin errors++; $display("FAIL step_toggle: got %b, required 0", paused); end
    wait_edge(q + 29);
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL simul_pending: %0d ticks outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    int c0, s, d;
    reset = 1'b1;
    exp_tc = 0;
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    c0 = cyc;
    for (int i = 2; i <= 6; i++) begin
      expect_tick(c0 + i);
      drive(c0 + i, 0, 1, 0, 0);
    end
    drive(c0 + 7, 0, 0, 1, 0);
    drive(c0 + 8, 0, 0, 1, 0);
    s = c0 + 9;
    drive(s, 1, 0, 0, 0);
    wait_edge(s + 8);
    vectors += 2;
    if (level !== 3'd2) begin errors++; $display("FAIL pre_level: got %0d, required 2", level); end
    if (tick_count !== 16'd5) begin errors++; $display("FAIL pre_count: got %0d, required 5", tick_count); end
    reset = 1'b1;
    #1;
    vectors += 4;
    if (game_tick !== 1'b0) begin errors++; $display("FAIL mid_reset_tick: got %b, required 0", game_tick); end
    if (level !== 3'd0) begin errors++; $display("FAIL mid_reset_level: got %0d, required 0", level); end
    if (tick_count !== 16'd0) begin errors++; $display("FAIL mid_reset_count: got %0d, required 0", tick_count); end
    if (paused !== 1'b1) begin errors++; $display("FAIL mid_reset_paused: got %b, required 1", paused); end
    exp_tc = 0;
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    d = cyc;
    expect_tick(d + 11);
    drive(d + 1, 1, 0, 0, 0);
    wait_edge(d + 12);
    vectors += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL post_reset_pending: %0d ticks outstanding, required 0", exp_q.size()); end
    if (tick_count !== 16'd1) begin errors++; $display("FAIL post_reset_count: got %0d, required 1", tick_count); end
  endtask

  initial begin
    reset = 1'b1;
    pause_toggle = 1'b0; step = 1'b0; level_up = 1'b0; level_clr = 1'b0;
    test_reset;
    test_run_rate;
    test_level;
    test_pause;
    test_step;
    test_simultaneous;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/game_tick_gen.md
# game_tick_gen

Parametrised game-rate tick generator for the snake core. It derives a one-cycle `game_tick` strobe from the 100 MHz system clock at a period set by a difficulty level. It adds run/pause control, single-step while paused, and a running tick count. It replaces the fixed-rate divider and feeds the snake movement FSM, food logic and score logic.

## Interface
- `BASE_PERIOD`, default 20_000_000: tick period in clk cycles at level 0 (5 Hz).
- `STEP`, default 2_000_000: period reduction per level, in cycles.
- `MIN_PERIOD`, default 5_000_000: floor on the period (20 Hz). Must be ≥ 2.
- `LEVEL_W`, default 4: level width. Max level is 2^LEVEL_W−1.
- `CNT_W`, default 26: counter width. Must hold BASE_PERIOD−1.
- `START_PAUSED`, default 1: state after reset. 1 = PAUSED, 0 = RUN.
- `clk_100MHz`  in  1  system clock. Reset is asynchronous, active-high; clock is clk_100MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `pause_toggle`  in  1  one-cycle pulse that toggles between RUN and PAUSED.
- `step`  in  1  one-cycle pulse requesting a single tick while PAUSED.
- `level_up`  in  1  one-cycle pulse that increments the level (saturating).
- `level_clr`  in  1  one-cycle pulse that sets the level to 0.
- `game_tick`  out  1  registered one-cycle tick strobe.
- `paused`  out  1  high in the PAUSED state.
- `level`  out  LEVEL_W  current difficulty level.
- `tick_count`  out  16  number of ticks issued since reset.

## Operation
- FSM with two states: RUN and PAUSED.
  - `pause_toggle` flips the state at the sampling edge.
  - Reset state is PAUSED if START_PAUSED=1, otherwise RUN.
  - `paused` = (state == PAUSED).
- Period arithmetic:
  - next_period = max(BASE_PERIOD − level·STEP, MIN_PERIOD).
  - Compute in a width that holds BASE_PERIOD. Clamp before truncation; no negative wrap.
  - `period_q` is a register. It loads next_period at reset and at every counter wrap. A level change therefore never truncates or extends the interval already in progress.
- Counter in RUN:
  - On each edge where the state before the edge is RUN:
    - if counter == period_q−1, then counter←0, game_tick←1, tick_count←tick_count+1, period_q←next_period;
    - otherwise counter←counter+1 and game_tick←0.
- Counter in PAUSED:
  - counter holds its value; game_tick←0.
  - `step` in PAUSED sets game_tick←1 and increments tick_count. It does not modify counter or period_q.
  - `step` in RUN is ignored.
- Level:
  - `level_up` increments level, saturating at 2^LEVEL_W−1.
  - `level_clr` sets level to 0. If both pulses arrive in the same cycle, `level_clr` wins.
  - Level updates immediately; the resulting period takes effect at the next wrap.
- `tick_count` wraps 0xFFFF→0x0000. It is cleared only by reset.
- Simultaneous events:
  - `pause_toggle` on the wrap edge: the wrap still completes (tick emitted, counter←0), then the state becomes PAUSED.
  - `pause_toggle` together with `step` while PAUSED: the step tick is emitted and the state becomes RUN; counter is unchanged.
- Reset mid-interval: all state is re-initialised immediately. No tick is produced during reset or on the first edge after deassertion.

## Timing
- Reset values:
  - game_tick = 0, level = 0, tick_count = 0, counter = 0.
  - period_q = next_period evaluated at level 0 = max(BASE_PERIOD, MIN_PERIOD).
  - paused = START_PAUSED.
- Steady RUN: game_tick is high for exactly 1 cycle every period_q cycles.
- First tick: after entering RUN from counter=0, game_tick rises period_q cycles after the edge that sampled `pause_toggle`.
- Pause/resume: the interval in progress completes after exactly period_q cycles spent in RUN, summed across pauses.
- Step: game_tick is high in the cycle after the edge that samples `step`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
Parameters for all tests: BASE_PERIOD=10, STEP=2, MIN_PERIOD=4, LEVEL_W=3, START_PAUSED=1.
- Run rate: reset, then `pause_toggle` at edge E0 → paused=0. Ticks appear after E10, E20, E30, each 1 cycle wide. tick_count reads 1, 2, 3.
- Level change applies at the next wrap: in RUN, `level_up` ×3 at counter=3 → level=3. The current interval still lasts 10 cycles; following intervals are 4 cycles. Two more `level_up` → level=5, period stays 4 (clamped). Five more pulses → level saturates at 7.
- Pause in mid-interval: pause at counter=4, hold 50 cycles, resume → no tick while paused. The next tick arrives 6 RUN cycles after resume; counter still equals 4 throughout the pause.
- Step: while PAUSED, `step` → one 1-cycle tick, tick_count+1, counter unchanged. `step` while in RUN → no extra tick.
- Simultaneous events: `level_up` and `level_clr` in the same cycle at level 6 → level=0. `pause_toggle` on the wrap edge → tick emitted, then paused=1.
- Reset: assert reset at counter=7 with level=2 and tick_count=5 → game_tick=0, level=0, tick_count=0, paused=1 immediately. No tick within 10 cycles after deassertion.
